uart_byte_rx: RTL and testbench

- Hardware UART receiver for the FPGA pin UART_RX: deserializes 8N1 frames from the host into bytes and presents them on a ready/valid stream.
- Uses 16x oversampling with mid-bit majority vote; flags framing and overrun errors.
- Runs on the CLK_100M domain beside CPU_qsys. Feeds FIR sample bytes to fabric logic without CPU involvement.

---
 rtl/uart_byte_rx_if.sv | 20 ++
 rtl/uart_byte_rx.sv | 116 +++++++++++
 tb/tb_uart_byte_rx.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: received-byte ready/valid stream plus status pulses.
// PARITY_ERR exists only when UART_RX_PARITY_EN is defined.
interface uart_byte_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] RX_DATA;
  logic RX_VALID;
  logic RX_READY;
  logic FRAME_ERR;
  logic OVERRUN;
  logic BUSY;
`ifdef UART_RX_PARITY_EN
  logic PARITY_ERR;
  modport master(output RX_DATA, RX_VALID, FRAME_ERR, OVERRUN, BUSY, PARITY_ERR, input RX_READY);
  modport slave(input RX_DATA, RX_VALID, FRAME_ERR, OVERRUN, BUSY, PARITY_ERR, output RX_READY);
`else
  modport master(output RX_DATA, RX_VALID, FRAME_ERR, OVERRUN, BUSY, input RX_READY);
  modport slave(input RX_DATA, RX_VALID, FRAME_ERR, OVERRUN, BUSY, output RX_READY);
`endif
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 16x-oversampled UART receiver, mid-bit 3-sample majority vote, ready/valid byte output.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_byte_rx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          UART_RXD,
  uart_byte_rx_if.master rx
);
  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = DIV_RAW > 1 ? DIV_RAW : 1;
  localparam int DW      = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW      = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t               r_state, w_next;
  logic                 r_s1, r_s2, r_prev;
  logic [DW-1:0]        r_div;
  logic [3:0]           r_tick;
  logic [BW-1:0]        r_bit;
  logic [1:0]           r_smp;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_valid, r_ferr, r_ovr;
  logic                 w_rx, w_fall, w_tick, w_mid, w_end, w_maj, w_eval, w_pok, w_good, w_load;

  assign w_rx   = r_s2;
  assign w_fall = !r_s2 && r_prev;
  // The start-detect cycle itself counts as tick 0 of the start cell, recovering synchronizer delay.
  assign w_tick = (r_state == IDLE) ? w_fall : (r_div == DW'(DIV - 1));
  assign w_mid  = w_tick && (r_tick == 4'd9);
  assign w_end  = w_tick && (r_tick == 4'd15);
  assign w_maj  = (r_smp[1] & r_smp[0]) | (r_smp[1] & w_rx) | (r_smp[0] & w_rx);
  assign w_eval = (r_state == STOP) && w_mid;
  assign w_good = w_eval && w_maj && w_pok;
  assign w_load = w_good && (!r_valid || rx.RX_READY);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_fall ? START : IDLE;
      START:   w_next = (w_mid && w_maj) ? IDLE : (w_end ? DATA : START);
      DATA:    w_next = (w_end && r_bit == BW'(DATA_BITS - 1)) ? AFTER_DATA : DATA;
      PARITY:  w_next = w_end ? STOP : PARITY;
      STOP:    w_next = w_mid ? (w_maj ? IDLE : BRK) : STOP;
      BRK:     w_next = w_rx ? IDLE : BRK;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_prev  <= 1'b0;
      r_div   <= '0;
      r_tick  <= '0;
      r_bit   <= '0;
      r_smp   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_s1    <= UART_RXD;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_div   <= (r_state == IDLE || w_tick) ? '0 : r_div + 1'b1;
      r_tick  <= (w_next == IDLE) ? '0 : r_tick + 4'(w_tick);
      r_bit   <= (r_state != DATA) ? '0 : r_bit + BW'(w_end);
      if (w_tick && (r_tick == 4'd7 || r_tick == 4'd8)) r_smp <= {r_smp[0], w_rx};
      if (r_state == DATA && w_mid) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
      if (w_load) r_data <= r_shift;
      r_valid <= w_load || (r_valid && !rx.RX_READY);
      r_ferr  <= w_eval && !w_maj;
      r_ovr   <= w_good && r_valid && !rx.RX_READY;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_pok, r_perr;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pok  <= 1'b1;
      r_perr <= 1'b0;
    end else begin
      if (r_state == PARITY && w_mid) r_pok <= ~^{r_shift, w_maj};
      r_perr <= w_eval && !r_pok;
    end
  end
  assign w_pok         = r_pok;
  assign rx.PARITY_ERR = r_perr;
`else
  assign w_pok = 1'b1;
`endif

  assign rx.RX_DATA   = r_data;
  assign rx.RX_VALID  = r_valid;
  assign rx.FRAME_ERR = r_ferr;
  assign rx.OVERRUN   = r_ovr;
  assign rx.BUSY      = (r_state != IDLE);
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed corner cases plus randomized frames checked against a frame-level model.
// Inputs change 1 time unit after a rising edge; outputs are observed on falling edges.
module tb_uart_byte_rx;
  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int CELL     = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAT_LO = CELL * (NB - 1) + 9;
  localparam int LAT_HI = CELL * (NB - 1) + 13;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic UART_RXD = 1'b1;
  uart_byte_rx_if #(.DATA_BITS(8)) rx();

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .UART_RXD(UART_RXD),
    .rx(rx.master)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_perr = 0;
  logic [7:0] got_q[$];

  always @(negedge CLK) begin
    if (rx.RX_VALID && rx.RX_READY) got_q.push_back(rx.RX_DATA);
    if (rx.FRAME_ERR) n_ferr++;
    if (rx.OVERRUN) n_ovr++;
`ifdef UART_RX_PARITY_EN
    if (rx.PARITY_ERR) n_perr++;
`endif
  end

  bit m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] exp_q[$];
  int e_ferr = 0;
  int e_ovr = 0;
  int e_perr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_ready(input bit r);
    if (r && m_valid) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input bit sb, input bit pb, input bit r);
    bit pok;
    pok = (NB == 10) || !(^{d, pb});
    if (!sb) e_ferr++;
    if (!pok) e_perr++;
    if (sb && pok) begin
      if (r) exp_q.push_back(d);
      else if (m_valid) e_ovr++;
      else begin
        m_valid = 1'b1;
        m_data = d;
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit sb, input bit pb);
    logic [10:0] f;
    f = (NB == 11) ? {sb, pb, d, 1'b0} : {1'b1, sb, d, 1'b0};
    for (int i = 0; i < NB; i++) begin
      UART_RXD = f[i];
      cyc(CELL);
    end
    UART_RXD = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, vcnt, t_load, f0, q0, gap;
    logic [7:0] d0, d;
    bit r, sb, pb, last_bad;
    rx.RX_READY = 1'b0;
    cyc(3);
    @(negedge CLK);
    chk("rst_data", rx.RX_DATA, 8'h00);
    chk("rst_valid", rx.RX_VALID, 1'b0);
    chk("rst_ferr", rx.FRAME_ERR, 1'b0);
    chk("rst_ovr", rx.OVERRUN, 1'b0);
    chk("rst_busy", rx.BUSY, 1'b0);
    cyc(1);
    RST = 1'b0;
    cyc(6);

    rx.RX_READY = 1'b1;
    model_ready(1'b1);
    lat = 0;
    vcnt = 0;
    d0 = 8'h00;
    fork
      send(8'h55, 1'b1, ^8'h55);
      begin
        while (!rx.RX_VALID && lat < 400) begin
          @(negedge CLK);
          lat++;
        end
        d0 = rx.RX_DATA;
        while (rx.RX_VALID && vcnt < 400) begin
          vcnt++;
          @(negedge CLK);
        end
      end
    join
    model_frame(8'h55, 1'b1, ^8'h55, 1'b1);
    t_load = lat - 1;
    chk("lat_window", (t_load >= LAT_LO) && (t_load <= LAT_HI), 1'b1);
    chk("t1_data", d0, 8'h55);
    chk("t1_valid_cycles", vcnt, 1);
    @(negedge CLK);
    chk("t1_busy_after", rx.BUSY, 1'b0);
    cyc(4);

    f0 = n_ferr;
    q0 = got_q.size();
    UART_RXD = 1'b0;
    cyc(4);
    UART_RXD = 1'b1;
    cyc(3);
    @(negedge CLK);
    chk("glitch_busy_mid", rx.BUSY, 1'b1);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk("glitch_busy_low", rx.BUSY, 1'b0);
    cyc(20);
    chk("glitch_no_ferr", n_ferr, f0);
    chk("glitch_no_byte", got_q.size(), q0);

    send(8'hA3, 1'b0, ^8'hA3);
    model_frame(8'hA3, 1'b0, ^8'hA3, 1'b1);
    cyc(8);
    send(8'h3C, 1'b1, ^8'h3C);
    model_frame(8'h3C, 1'b1, ^8'h3C, 1'b1);
    cyc(4);
    chk("ferr_count", n_ferr, e_ferr);
    chk("ferr_bytes", got_q.size(), exp_q.size());

    rx.RX_READY = 1'b0;
    send(8'h12, 1'b1, ^8'h12);
    model_frame(8'h12, 1'b1, ^8'h12, 1'b0);
    send(8'h34, 1'b1, ^8'h34);
    model_frame(8'h34, 1'b1, ^8'h34, 1'b0);
    cyc(4);
    @(negedge CLK);
    chk("ovr_data_held", rx.RX_DATA, 8'h12);
    chk("ovr_valid", rx.RX_VALID, 1'b1);
    chk("ovr_count", n_ovr, e_ovr);
    @(posedge CLK);
    #1;
    rx.RX_READY = 1'b1;
    model_ready(1'b1);
    cyc(1);
    rx.RX_READY = 1'b0;
    @(negedge CLK);
    chk("ovr_drain_valid", rx.RX_VALID, 1'b0);
    cyc(4);

    send(8'h12, 1'b1, ^8'h12);
    model_frame(8'h12, 1'b1, ^8'h12, 1'b0);
    cyc(3);
    fork
      send(8'h34, 1'b1, ^8'h34);
      begin
        cyc(t_load - 1);
        rx.RX_READY = 1'b1;
        cyc(1);
        rx.RX_READY = 1'b0;
      end
    join
    model_ready(1'b1);
    model_frame(8'h34, 1'b1, ^8'h34, 1'b0);
    cyc(2);
    @(negedge CLK);
    chk("same_cyc_data", rx.RX_DATA, 8'h34);
    chk("same_cyc_valid", rx.RX_VALID, 1'b1);
    chk("same_cyc_no_ovr", n_ovr, e_ovr);
    @(posedge CLK);
    #1;
    rx.RX_READY = 1'b1;
    model_ready(1'b1);
    cyc(3);

    rx.RX_READY = 1'b0;
    send(8'h5A, 1'b1, ^8'h5A);
    model_frame(8'h5A, 1'b1, ^8'h5A, 1'b0);
    cyc(3);
    f0 = n_ferr;
    q0 = got_q.size();
    fork
      send(8'hFF, 1'b1, 1'b1);
      begin
        cyc(CELL * 4 + 8);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_mid_valid", rx.RX_VALID, 1'b0);
        chk("rst_mid_busy", rx.BUSY, 1'b0);
      end
    join
    m_valid = 1'b0;
    cyc(20);
    rx.RX_READY = 1'b1;
    cyc(4);
    chk("rst_mid_no_ferr", n_ferr, f0);
    chk("rst_mid_no_byte", got_q.size(), q0);

`ifdef UART_RX_PARITY_EN
    model_ready(1'b1);
    send(8'h07, 1'b1, 1'b0);
    model_frame(8'h07, 1'b1, 1'b0, 1'b1);
    cyc(4);
    chk("par_bad_perr", n_perr, e_perr);
    chk("par_bad_bytes", got_q.size(), exp_q.size());
    send(8'h07, 1'b1, 1'b1);
    model_frame(8'h07, 1'b1, 1'b1, 1'b1);
    cyc(4);
    chk("par_good_bytes", got_q.size(), exp_q.size());
`endif

    last_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      d = 8'($urandom);
      r = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 5) != 0);
      pb = (^d) ^ ($urandom_range(0, 4) == 0);
      gap = last_bad ? int'($urandom_range(4, 20)) : int'($urandom_range(0, 20));
      rx.RX_READY = r;
      model_ready(r);
      cyc(gap);
      send(d, sb, pb);
      model_frame(d, sb, pb, r);
      last_bad = !sb;
    end
    rx.RX_READY = 1'b1;
    model_ready(1'b1);
    cyc(30);

    chk("final_nbytes", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("byte%0d", i), got_q[i], exp_q[i]);
    chk("final_ferr", n_ferr, e_ferr);
    chk("final_ovr", n_ovr, e_ovr);
    chk("final_perr", n_perr, e_perr);
    @(negedge CLK);
    chk("final_busy", rx.BUSY, 1'b0);
    chk("final_valid", rx.RX_VALID, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
